// File: rtl/lcd_pkg.sv
// Shared constants, encodings and helpers for the character-LCD message writer.
// Covers the HD44780 command bytes, the message text and the BCD conversion step.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_LINE0    = 8'h80;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    // Full 16-char lines, leftmost character in the top byte.
    localparam logic [127:0] STR_WAIT  = "WAIT...         ";
    localparam logic [127:0] STR_CHEAT = "CHEATER!        ";
    localparam logic [127:0] STR_SLOW  = "TOO SLOW        ";
    localparam logic [127:0] STR_TIME  = "TIME:      MS   ";

    typedef enum logic [1:0] {MSG_TIME, MSG_WAIT, MSG_CHEAT, MSG_SLOW} msg_sel_t;

    typedef enum logic [2:0] {
        ST_PWRUP, ST_INIT, ST_IDLE, ST_CONV, ST_CLR, ST_ADDR, ST_CHARS
    } top_state_t;

    typedef enum logic [1:0] {BW_IDLE, BW_SETUP, BW_PULSE, BW_WAIT} bw_state_t;

    function automatic msg_sel_t select_msg(input logic cheat, input logic slow,
                                            input logic wait_sel);
        if (cheat)         return MSG_CHEAT;
        else if (slow)     return MSG_SLOW;
        else if (wait_sel) return MSG_WAIT;
        else               return MSG_TIME;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY;
        endcase
    endfunction

    function automatic logic [7:0] str_char(input logic [127:0] s, input logic [3:0] i);
        return s[8 * (15 - int'(i)) +: 8];
    endfunction

    // Double-dabble add-3 stage applied before each left shift.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
        logic [15:0] r;
        r = bcd;
        for (int n = 0; n < 4; n++) begin
            if (bcd[4*n +: 4] >= 4'd5) r[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_message_writer_if.sv
// Request/acknowledge handshake between the reaction-timer FSM (master) and the LCD writer (slave).
interface lcd_message_writer_if;
    logic       LCDUpdate;
    logic       Wait;
    logic       Cheat;
    logic       Slow;
    logic [9:0] ReactionTime;
    logic       LCDAck;
    logic       Busy;

    modport master (output LCDUpdate, Wait, Cheat, Slow, ReactionTime,
                    input  LCDAck, Busy);
    modport slave  (input  LCDUpdate, Wait, Cheat, Slow, ReactionTime,
                    output LCDAck, Busy);
endinterface

// File: rtl/lcd_byte_writer.sv
// Writes one byte to the LCD bus: one setup cycle, an E strobe, then the controller's
// execution wait (long wait for the clear command). Pulses done in the last wait cycle.
module lcd_byte_writer #(
    parameter int unsigned E_PULSE_CYC    = 12,
    parameter int unsigned CHAR_WAIT_CYC  = 2500,
    parameter int unsigned CLEAR_WAIT_CYC = 100000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       done,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic [7:0] LCD_DB
);
    import lcd_pkg::*;

    localparam int unsigned MAX_WAIT = (CLEAR_WAIT_CYC > CHAR_WAIT_CYC) ? CLEAR_WAIT_CYC
                                                                        : CHAR_WAIT_CYC;
    localparam int unsigned MAX_CYC  = (MAX_WAIT > E_PULSE_CYC) ? MAX_WAIT : E_PULSE_CYC;
    localparam int unsigned CNT_W    = $clog2(MAX_CYC + 1);

    bw_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wait_last;
    logic             load;

    assign wait_last = (!LCD_RS && LCD_DB == CMD_CLEAR) ? CNT_W'(CLEAR_WAIT_CYC - 1)
                                                        : CNT_W'(CHAR_WAIT_CYC - 1);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        load    = 1'b0;
        case (state_q)
            BW_IDLE: if (start) begin
                state_d = BW_SETUP;
                load    = 1'b1;
            end
            BW_SETUP: begin
                state_d = BW_PULSE;
                cnt_d   = '0;
            end
            BW_PULSE: if (cnt_q == CNT_W'(E_PULSE_CYC - 1)) begin
                state_d = BW_WAIT;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            BW_WAIT: if (cnt_q == wait_last) begin
                state_d = BW_IDLE;
                cnt_d   = '0;
                done    = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = BW_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= BW_IDLE;
            cnt_q   <= '0;
            LCD_E   <= 1'b0;
            LCD_RS  <= 1'b0;
            LCD_DB  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            LCD_E   <= (state_d == BW_PULSE);
            if (load) begin
                LCD_RS <= rs;
                LCD_DB <= data;
            end
        end
    end

endmodule

// File: rtl/lcd_message_writer.sv
// Captures a message request, acknowledges it and writes one 16-char line to an HD44780 LCD,
// running the power-up init sequence after every reset.
module lcd_message_writer #(
    parameter int unsigned POWERUP_CYC    = 750000,
    parameter int unsigned E_PULSE_CYC    = 12,
    parameter int unsigned CHAR_WAIT_CYC  = 2500,
    parameter int unsigned CLEAR_WAIT_CYC = 100000
) (
    input  logic                 Clk,
    input  logic                 Rst,
    lcd_message_writer_if.slave  req,
    output logic                 LCD_RS,
    output logic                 LCD_RW,
    output logic                 LCD_E,
    output logic [7:0]           LCD_DB
);
    import lcd_pkg::*;

    localparam int unsigned PW = $clog2(POWERUP_CYC + 1);

    top_state_t    state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [PW-1:0] pwr_cnt_q, pwr_cnt_d;
    logic          issued_q, issued_d;
    logic          armed_q, armed_d;
    logic          ack_q;
    logic          capture, conv_step;
    msg_sel_t      sel_in, sel_q;
    logic [9:0]    bin_q;
    logic [15:0]   bcd_q, bcd_adj;
    logic          bw_start, bw_rs, bw_done;
    logic [7:0]    bw_data;

    assign sel_in     = select_msg(req.Cheat, req.Slow, req.Wait);
    assign bcd_adj    = dabble_adjust(bcd_q);
    assign req.LCDAck = ack_q;
    assign req.Busy   = (state_q != ST_IDLE);
    assign LCD_RW     = 1'b0;

    function automatic logic [7:0] time_char(input logic [3:0] i, input logic [15:0] bcd);
        case (i)
            4'd6:    return (bcd[15:12] == 4'd0) ? ASCII_SPACE : ASCII_ZERO + {4'h0, bcd[15:12]};
            4'd7:    return (bcd[15:8] == 8'd0)  ? ASCII_SPACE : ASCII_ZERO + {4'h0, bcd[11:8]};
            4'd8:    return (bcd[15:4] == 12'd0) ? ASCII_SPACE : ASCII_ZERO + {4'h0, bcd[7:4]};
            4'd9:    return ASCII_ZERO + {4'h0, bcd[3:0]};
            default: return str_char(STR_TIME, i);
        endcase
    endfunction

    always_comb begin
        bw_rs   = 1'b0;
        bw_data = CMD_CLEAR;
        case (state_q)
            ST_INIT: bw_data = init_cmd(idx_q[1:0]);
            ST_ADDR: bw_data = CMD_LINE0;
            ST_CHARS: begin
                bw_rs = 1'b1;
                case (sel_q)
                    MSG_WAIT:  bw_data = str_char(STR_WAIT, idx_q);
                    MSG_CHEAT: bw_data = str_char(STR_CHEAT, idx_q);
                    MSG_SLOW:  bw_data = str_char(STR_SLOW, idx_q);
                    default:   bw_data = time_char(idx_q, bcd_q);
                endcase
            end
            default: ;
        endcase
    end

    // Re-arm whenever LCDUpdate is seen low; a captured request disarms until then.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pwr_cnt_d = pwr_cnt_q;
        issued_d  = issued_q;
        armed_d   = armed_q | ~req.LCDUpdate;
        bw_start  = 1'b0;
        capture   = 1'b0;
        conv_step = 1'b0;
        case (state_q)
            ST_PWRUP: if (pwr_cnt_q == PW'(POWERUP_CYC - 1)) begin
                state_d = ST_INIT;
                idx_d   = '0;
            end else begin
                pwr_cnt_d = pwr_cnt_q + 1'b1;
            end
            ST_IDLE: if (armed_q && req.LCDUpdate) begin
                capture = 1'b1;
                armed_d = 1'b0;
                idx_d   = '0;
                state_d = (sel_in == MSG_TIME) ? ST_CONV : ST_CLR;
            end
            ST_CONV: begin
                conv_step = 1'b1;
                if (idx_q == 4'd9) begin
                    state_d = ST_CLR;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_INIT, ST_CLR, ST_ADDR, ST_CHARS: begin
                bw_start = ~issued_q;
                issued_d = 1'b1;
                if (bw_done) begin
                    issued_d = 1'b0;
                    case (state_q)
                        ST_INIT:  if (idx_q == 4'd3) state_d = ST_IDLE;
                                  else idx_d = idx_q + 1'b1;
                        ST_CLR:   state_d = ST_ADDR;
                        ST_ADDR:  begin state_d = ST_CHARS; idx_d = '0; end
                        default:  if (idx_q == 4'd15) state_d = ST_IDLE;
                                  else idx_d = idx_q + 1'b1;
                    endcase
                end
            end
            default: state_d = ST_PWRUP;
        endcase
    end

    // NOTE: message/time capture registers are reset too, so an aborted write leaves nothing behind.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= ST_PWRUP;
            idx_q     <= '0;
            pwr_cnt_q <= '0;
            issued_q  <= 1'b0;
            armed_q   <= 1'b1;
            ack_q     <= 1'b0;
            sel_q     <= MSG_TIME;
            bin_q     <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pwr_cnt_q <= pwr_cnt_d;
            issued_q  <= issued_d;
            armed_q   <= armed_d;
            ack_q     <= capture;
            if (capture) begin
                sel_q <= sel_in;
                bin_q <= req.ReactionTime;
                bcd_q <= '0;
            end else if (conv_step) begin
                {bcd_q, bin_q} <= {bcd_adj[14:0], bin_q, 1'b0};
            end
        end
    end

    lcd_byte_writer #(
        .E_PULSE_CYC    (E_PULSE_CYC),
        .CHAR_WAIT_CYC  (CHAR_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
    ) u_byte_writer (
        .Clk    (Clk),
        .Rst    (Rst),
        .start  (bw_start),
        .rs     (bw_rs),
        .data   (bw_data),
        .done   (bw_done),
        .LCD_E  (LCD_E),
        .LCD_RS (LCD_RS),
        .LCD_DB (LCD_DB)
    );

endmodule

// File: tb/tb_lcd_message_writer.sv
// Directed bench for lcd_message_writer: init sequence, message text, handshake and reset abort.
module tb_lcd_message_writer;

    localparam int POWERUP_CYC    = 20;
    localparam int E_PULSE_CYC    = 2;
    localparam int CHAR_WAIT_CYC  = 4;
    localparam int CLEAR_WAIT_CYC = 8;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       LCD_RS, LCD_RW, LCD_E;
    logic [7:0] LCD_DB;

    lcd_message_writer_if bus();

    lcd_message_writer #(
        .POWERUP_CYC    (POWERUP_CYC),
        .E_PULSE_CYC    (E_PULSE_CYC),
        .CHAR_WAIT_CYC  (CHAR_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
    ) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .req    (bus.slave),
        .LCD_RS (LCD_RS),
        .LCD_RW (LCD_RW),
        .LCD_E  (LCD_E),
        .LCD_DB (LCD_DB)
    );

    always #5 Clk = ~Clk;

    int         checks = 0;
    int         failures = 0;
    logic [8:0] cap_q[$];
    int         ack_count = 0;
    int         proto_viol = 0;
    int         cycle = 0;
    int         first_e = -1;
    int         e_width = 0;
    logic       e_prev = 1'b0;
    logic       ack_prev = 1'b0;
    logic [8:0] bus_prev = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor: records {RS,DB} at each E rise and counts protocol violations.
    always @(negedge Clk) begin
        cycle++;
        if (Rst) begin
            e_prev   = 1'b0;
            ack_prev = 1'b0;
            e_width  = 0;
        end else begin
            if (LCD_E && !e_prev) begin
                cap_q.push_back({LCD_RS, LCD_DB});
                if (first_e < 0) first_e = cycle;
            end
            if (LCD_E && e_prev && {LCD_RS, LCD_DB} != bus_prev) proto_viol++;
            if (LCD_E) e_width++;
            else if (e_prev) begin
                if (e_width != E_PULSE_CYC) proto_viol++;
                e_width = 0;
            end
            if (bus.LCDAck) ack_count++;
            if (bus.LCDAck && ack_prev) proto_viol++;
            if (LCD_RW) proto_viol++;
            e_prev   = LCD_E;
            ack_prev = bus.LCDAck;
            bus_prev = {LCD_RS, LCD_DB};
        end
    end

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.Busy !== 1'b0 && n < 5000) begin
            @(negedge Clk);
            n++;
        end
        check({tag, "_idle"}, {31'd0, bus.Busy}, 32'd0);
    endtask

    task automatic send_req(input string tag, input logic w, input logic c, input logic s,
                            input logic [9:0] t, input int hold);
        int n = 0;
        bus.Wait = w; bus.Cheat = c; bus.Slow = s; bus.ReactionTime = t;
        bus.LCDUpdate = 1'b1;
        do begin
            @(negedge Clk);
            n++;
        end while (bus.LCDAck !== 1'b1 && n < 2000);
        check({tag, "_ack"}, {31'd0, bus.LCDAck}, 32'd1);
        // Inputs changing after capture must not affect the line being written.
        bus.Wait = ~w; bus.Cheat = ~c; bus.Slow = ~s; bus.ReactionTime = ~t;
        @(negedge Clk);
        check({tag, "_ack_width"}, {31'd0, bus.LCDAck}, 32'd0);
        repeat (hold - 1) @(negedge Clk);
        bus.LCDUpdate = 1'b0;
        bus.Wait = 1'b0; bus.Cheat = 1'b0; bus.Slow = 1'b0;
    endtask

    task automatic check_init(input string tag);
        logic [8:0] exp[4];
        exp[0] = 9'h038; exp[1] = 9'h00C; exp[2] = 9'h001; exp[3] = 9'h006;
        check({tag, "_count"}, cap_q.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_b%0d", tag, i), (i < cap_q.size()) ? cap_q[i] : 9'h1FF, exp[i]);
    endtask

    task automatic check_msg(input string tag, input string text);
        logic [8:0] exp;
        check({tag, "_count"}, cap_q.size(), 32'd18);
        for (int i = 0; i < 18; i++) begin
            if (i == 0)      exp = 9'h001;
            else if (i == 1) exp = 9'h080;
            else             exp = {1'b1, text[i-2]};
            check($sformatf("%s_b%0d", tag, i), (i < cap_q.size()) ? cap_q[i] : 9'h1FF, exp);
        end
    endtask

    task automatic run_msg(input string tag, input logic w, input logic c, input logic s,
                           input logic [9:0] t, input int hold, input string text);
        int a0;
        cap_q.delete();
        a0 = ack_count;
        send_req(tag, w, c, s, t, hold);
        wait_idle(tag);
        repeat (3) @(negedge Clk);
        check({tag, "_acks"}, ack_count - a0, 32'd1);
        check_msg(tag, text);
    endtask

    initial begin
        int rel;
        int a0;
        int n;
        bus.LCDUpdate = 1'b0; bus.Wait = 1'b0; bus.Cheat = 1'b0; bus.Slow = 1'b0;
        bus.ReactionTime = '0;
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst_e",    {31'd0, LCD_E},      32'd0);
        check("rst_rs",   {31'd0, LCD_RS},     32'd0);
        check("rst_rw",   {31'd0, LCD_RW},     32'd0);
        check("rst_db",   {24'd0, LCD_DB},     32'd0);
        check("rst_ack",  {31'd0, bus.LCDAck}, 32'd0);
        check("rst_busy", {31'd0, bus.Busy},   32'd1);

        // Power-up delay then the four init commands.
        cap_q.delete();
        first_e = -1;
        rel = cycle;
        Rst = 1'b0;
        wait_idle("init");
        check("init_gap", {31'd0, (first_e - rel) > POWERUP_CYC}, 32'd1);
        check_init("init");

        run_msg("wait",   1'b1, 1'b0, 1'b0, 10'd0,    1, "WAIT...         ");
        run_msg("t347",   1'b0, 1'b0, 1'b0, 10'd347,  1, "TIME:  347 MS   ");
        run_msg("t0",     1'b0, 1'b0, 1'b0, 10'd0,    1, "TIME:    0 MS   ");
        run_msg("t1023",  1'b0, 1'b0, 1'b0, 10'd1023, 1, "TIME: 1023 MS   ");
        run_msg("t100",   1'b0, 1'b0, 1'b0, 10'd100,  1, "TIME:  100 MS   ");
        run_msg("t9",     1'b0, 1'b0, 1'b0, 10'd9,    1, "TIME:    9 MS   ");
        run_msg("cheat",  1'b1, 1'b1, 1'b1, 10'd55,   4, "CHEATER!        ");
        run_msg("slow",   1'b1, 1'b0, 1'b1, 10'd55,   1, "TOO SLOW        ");

        // Request raised mid-write waits for the line to finish.
        cap_q.delete();
        send_req("first", 1'b1, 1'b0, 1'b0, 10'd0, 1);
        n = 0;
        while (cap_q.size() < 6 && n < 2000) begin @(negedge Clk); n++; end
        check("mid_write", {31'd0, bus.Busy}, 32'd1);
        a0 = ack_count;
        bus.Slow = 1'b1;
        bus.LCDUpdate = 1'b1;
        wait_idle("held");
        check("held_no_ack", ack_count - a0, 32'd0);
        check_msg("first", "WAIT...         ");
        cap_q.delete();
        n = 0;
        do begin @(negedge Clk); n++; end while (bus.LCDAck !== 1'b1 && n < 2000);
        check("held_ack", {31'd0, bus.LCDAck}, 32'd1);
        @(negedge Clk);
        bus.LCDUpdate = 1'b0;
        bus.Slow = 1'b0;
        wait_idle("held_done");
        check_msg("held", "TOO SLOW        ");

        // Reset during a character strobe aborts at once and reruns init.
        cap_q.delete();
        send_req("abort", 1'b0, 1'b0, 1'b0, 10'd512, 1);
        n = 0;
        while (!(cap_q.size() >= 8 && LCD_E === 1'b1) && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        check("abort_point", {31'd0, LCD_E}, 32'd1);
        Rst = 1'b1;
        #1;
        check("abort_e",    {31'd0, LCD_E},      32'd0);
        check("abort_db",   {24'd0, LCD_DB},     32'd0);
        check("abort_rs",   {31'd0, LCD_RS},     32'd0);
        check("abort_ack",  {31'd0, bus.LCDAck}, 32'd0);
        check("abort_busy", {31'd0, bus.Busy},   32'd1);
        repeat (2) @(negedge Clk);
        cap_q.delete();
        first_e = -1;
        rel = cycle;
        Rst = 1'b0;
        wait_idle("reinit");
        check("reinit_gap", {31'd0, (first_e - rel) > POWERUP_CYC}, 32'd1);
        check_init("reinit");
        run_msg("after", 1'b0, 1'b0, 1'b0, 10'd42, 1, "TIME:   42 MS   ");

        check("protocol", proto_viol, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
